// File: rtl/avalon_rsa_mem.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : avalon_rsa_mem
// Purpose  : 256-bit operand/result store for the RSA core with a 32-bit
//            host lane port; optional macro RSA_MEM_WAITSTATE_EN.
// Revision : 1.0
// =====================================================================
module avalon_rsa_mem #(
  parameter int DEPTH       = 40,
  parameter int EXPECT      = 38,
  parameter int WAIT_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  avs_address,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [255:0] avs_writedata,
  output logic         avs_waitrequest,
  output logic [255:0] avs_readdata,
  output logic         avs_readdatavalid,
  input  logic         host_wr_en,
  output logic         host_wr_ready,
  input  logic [8:0]   host_addr,
  input  logic [31:0]  host_wr_data,
  output logic [31:0]  host_rd_data,
  output logic [7:0]   res_count,
  output logic         res_done,
  output logic         err,
  input  logic         clr
);

  localparam int          c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [26:0] c_DEPTH_W = 27'(DEPTH);
  localparam logic [8:0]  c_EXPECT  = 9'(EXPECT);

  logic [255:0]    r_mem [DEPTH];
  logic [255:0]    r_rd_data;
  logic            r_rd_valid;
  logic [31:0]     r_host_rd;
  logic [7:0]      r_res_count;
  logic            r_res_done;
  logic            r_err;

  logic [26:0]     w_word;
  logic            w_in_range;
  logic [c_AW-1:0] w_idx;
  logic [26:0]     w_hword;
  logic            w_hin_range;
  logic [c_AW-1:0] w_hidx;
  logic [7:0]      w_lane_off;
  logic            w_cmd;
  logic            w_acc;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_host_wr;
  logic            w_cnt_inc;
  logic [7:0]      w_cnt_nxt;
  logic            w_err_set;
  logic            w_unused;

  assign w_word      = avs_address[31:5];
  assign w_in_range  = (w_word < c_DEPTH_W);
  assign w_idx       = c_AW'(w_word);
  assign w_hword     = {21'd0, host_addr[8:3]};
  assign w_hin_range = (w_hword < c_DEPTH_W);
  assign w_hidx      = c_AW'(host_addr[8:3]);
  assign w_lane_off  = {host_addr[2:0], 5'd0};
  assign w_cmd       = avs_read | avs_write;
  assign w_unused    = ^avs_address[4:0];

`ifdef RSA_MEM_WAITSTATE_EN
  localparam int              c_WW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [c_WW-1:0] c_WAIT = c_WW'(WAIT_CYCLES);

  logic [c_WW-1:0] r_wait_cnt;

  // Stall a newly presented command until the counter reaches the wait count.
  assign avs_waitrequest = w_cmd && (r_wait_cnt != c_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (!w_cmd || !avs_waitrequest) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  localparam int c_wait_unused = WAIT_CYCLES;

  assign avs_waitrequest = 1'b0;
`endif

  assign w_acc     = w_cmd & ~avs_waitrequest;
  assign w_wr_acc  = w_acc & avs_write;
  assign w_rd_acc  = w_acc & avs_read & ~avs_write;
  assign w_host_wr = host_wr_en & host_wr_ready & w_hin_range;
  assign w_cnt_inc = w_wr_acc && w_in_range && (w_word >= 27'd2);
  assign w_err_set = w_acc && (!w_in_range || (avs_read && avs_write));

  // Avalon has priority; host writes are refused in any cycle with an Avalon write.
  assign host_wr_ready = ~w_wr_acc;

  always_comb begin
    w_cnt_nxt = r_res_count;
    if (clr) begin
      w_cnt_nxt = 8'd0;
    end else if (w_cnt_inc && (r_res_count != 8'hFF)) begin
      w_cnt_nxt = r_res_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      r_mem[w_idx] <= avs_writedata;
    end else if (w_host_wr) begin
      r_mem[w_hidx][w_lane_off +: 32] <= host_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_host_rd   <= '0;
      r_res_count <= '0;
      r_res_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
      end
      r_host_rd   <= w_hin_range ? r_mem[w_hidx][w_lane_off +: 32] : '0;
      r_res_count <= w_cnt_nxt;
      r_res_done  <= ({1'b0, w_cnt_nxt} >= c_EXPECT);
      r_err       <= clr ? 1'b0 : (r_err | w_err_set);
    end
  end

  assign avs_readdata      = r_rd_data;
  assign avs_readdatavalid = r_rd_valid;
  assign host_rd_data      = r_host_rd;
  assign res_count         = r_res_count;
  assign res_done          = r_res_done;
  assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_avalon_rsa_mem.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : tb_avalon_rsa_mem
// Purpose  : Scoreboard bench for avalon_rsa_mem (honours RSA_MEM_WAITSTATE_EN).
// Revision : 1.0
// =====================================================================
module tb_avalon_rsa_mem;

  localparam int DEPTH  = 40;
  localparam int EXPECT = 38;
`ifdef RSA_MEM_WAITSTATE_EN
  localparam int WS = 3;
`else
  localparam int WS = 0;
`endif

  localparam int K_CNT = 0, K_DONE = 1, K_ERR = 2, K_WREQ = 3, K_HRDY = 4;
  localparam int K_VALID = 5, K_RDATA = 6, K_HRD = 7, K_PEND = 8;

  logic         clk;
  logic         reset_n;
  logic [31:0]  avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [255:0] avs_writedata;
  logic         avs_waitrequest;
  logic [255:0] avs_readdata;
  logic         avs_readdatavalid;
  logic         host_wr_en;
  logic         host_wr_ready;
  logic [8:0]   host_addr;
  logic [31:0]  host_wr_data;
  logic [31:0]  host_rd_data;
  logic [7:0]   res_count;
  logic         res_done;
  logic         err;
  logic         clr;

  avalon_rsa_mem #(.DEPTH(DEPTH), .EXPECT(EXPECT), .WAIT_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .host_wr_en(host_wr_en), .host_wr_ready(host_wr_ready), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_data(host_rd_data),
    .res_count(res_count), .res_done(res_done), .err(err), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    int           kind;
    logic [255:0] val;
  } exp_t;

  exp_t st_q[$];
  exp_t rd_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain memory image plus counters following the documented rules.
  logic [255:0] m_mem [DEPTH];
  int           m_cnt = 0;
  bit           m_err = 1'b0;

  function automatic string kname(int k);
    case (k)
      K_CNT:   return "res_count";
      K_DONE:  return "res_done";
      K_ERR:   return "err";
      K_WREQ:  return "waitrequest";
      K_HRDY:  return "host_wr_ready";
      K_VALID: return "readdatavalid";
      K_RDATA: return "readdata";
      K_HRD:   return "host_rd_data";
      default: return "pending_reads";
    endcase
  endfunction

  function automatic logic [255:0] actual(int k);
    case (k)
      K_CNT:   return 256'(res_count);
      K_DONE:  return 256'(res_done);
      K_ERR:   return 256'(err);
      K_WREQ:  return 256'(avs_waitrequest);
      K_HRDY:  return 256'(host_wr_ready);
      K_VALID: return 256'(avs_readdatavalid);
      K_RDATA: return avs_readdata;
      K_HRD:   return 256'(host_rd_data);
      K_PEND:  return 256'(rd_q.size());
      default: return '1;
    endcase
  endfunction

  // Monitor: compares every DUT response against the queued expectations.
  initial begin
    exp_t         e;
    logic [255:0] act;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (avs_readdatavalid) begin
          vectors++;
          if (rd_q.size() == 0 || rd_q[0].cyc != cyc) begin
            miscompares++;
            $display("FAIL read_valid: unexpected valid at cycle %0d, data %h", cyc, avs_readdata);
          end else begin
            e = rd_q.pop_front();
            if (avs_readdata !== e.val) begin
              miscompares++;
              $display("FAIL read_data: cycle %0d got %h expected %h", cyc, avs_readdata, e.val);
            end
          end
        end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
          vectors++;
          miscompares++;
          e = rd_q.pop_front();
          $display("FAIL read_valid: missing valid at cycle %0d (expected data %h)", cyc, e.val);
        end
      end
      for (int i = st_q.size() - 1; i >= 0; i--) begin
        if (st_q[i].cyc <= cyc) begin
          vectors++;
          act = actual(st_q[i].kind);
          if (st_q[i].cyc != cyc || act !== st_q[i].val) begin
            miscompares++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", kname(st_q[i].kind), cyc, act, st_q[i].val);
          end
          st_q.delete(i);
        end
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic expect_st(int c, int k, logic [255:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    st_q.push_back(e);
  endtask

  task automatic chk_status();
    expect_st(cyc, K_CNT, 256'(m_cnt));
    expect_st(cyc, K_DONE, 256'(m_cnt >= EXPECT));
    expect_st(cyc, K_ERR, 256'(m_err));
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Avalon command: held for WS stall cycles, accepted in the following one.
  task automatic av_cmd(bit rd, bit wr, int word, logic [255:0] data);
    int   k0;
    exp_t e;
    k0 = cyc;
    avs_address   = {word[26:0], 5'($urandom)};
    avs_read      = rd;
    avs_write     = wr;
    avs_writedata = data;
    for (int i = 0; i <= WS; i++) expect_st(k0 + i, K_WREQ, 256'(i < WS));
    repeat (WS + 1) @(posedge clk);
    #1;
    if (wr) begin
      if (word < DEPTH) begin
        m_mem[word] = data;
        if (word >= 2 && !clr) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
      end else begin
        m_err = 1'b1;
      end
      if (rd) m_err = 1'b1;
    end else if (rd) begin
      e.cyc  = cyc;
      e.kind = K_RDATA;
      e.val  = (word < DEPTH) ? m_mem[word] : '0;
      rd_q.push_back(e);
      if (word >= DEPTH) m_err = 1'b1;
    end
    if (clr) begin
      m_cnt = 0;
      m_err = 1'b0;
    end
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic host_wr(int word, int lane, logic [31:0] d);
    host_addr    = {word[5:0], lane[2:0]};
    host_wr_data = d;
    host_wr_en   = 1'b1;
    expect_st(cyc, K_HRDY, 256'(1));
    @(posedge clk);
    #1;
    if (word < DEPTH) m_mem[word][lane*32 +: 32] = d;
    host_wr_en = 1'b0;
  endtask

  task automatic host_rd(int word, int lane);
    host_addr = {word[5:0], lane[2:0]};
    expect_st(cyc + 1, K_HRD, 256'(m_mem[word][lane*32 +: 32]));
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  initial begin
    int          op;
    logic [31:0] hd;
    reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_st(cyc, K_VALID, '0);
    expect_st(cyc, K_RDATA, '0);
    expect_st(cyc, K_HRD, '0);
    expect_st(cyc, K_WREQ, '0);
    chk_status();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    for (int w = 0; w < DEPTH; w++)
      for (int l = 0; l < 8; l++) host_wr(w, l, $urandom);

    // Host preload of word 0, read back over Avalon.
    for (int l = 0; l < 8; l++) host_wr(0, l, 32'(l));
    av_cmd(1'b1, 1'b0, 0, '0);

    av_cmd(1'b0, 1'b1, 2, 256'h1234);
    chk_status();
    host_rd(2, 0);

    // Fill all result words; res_done must follow the 38th write.
    clr_pulse();
    for (int i = 0; i < EXPECT; i++) begin
      av_cmd(1'b0, 1'b1, 2 + i, rnd256());
      if (i >= EXPECT - 2) chk_status();
    end
    clr_pulse();
    chk_status();

    // Host write collides with an Avalon write and must be refused.
    hd = ~m_mem[3][63:32];
    fork
      av_cmd(1'b0, 1'b1, 6, rnd256());
      begin
        repeat (WS) begin @(posedge clk); #1; end
        host_addr    = {6'd3, 3'd1};
        host_wr_data = hd;
        host_wr_en   = 1'b1;
        expect_st(cyc, K_HRDY, '0);
        expect_st(cyc + 1, K_HRD, 256'(m_mem[3][63:32]));
        @(posedge clk);
        #1;
        host_wr_en = 1'b0;
        expect_st(cyc, K_HRDY, 256'(1));
        expect_st(cyc + 1, K_HRD, 256'(m_mem[3][63:32]));
        @(posedge clk);
        #1;
      end
    join
    host_wr(3, 1, hd);
    host_rd(3, 1);
    chk_status();

    // Out-of-range read, then simultaneous read+write.
    av_cmd(1'b1, 1'b0, DEPTH, '0);
    chk_status();
    clr_pulse();
    av_cmd(1'b1, 1'b1, 7, rnd256());
    idle(1);
    chk_status();
    av_cmd(1'b1, 1'b0, 7, '0);

    // clr wins over a same-cycle increment.
    clr = 1'b1;
    av_cmd(1'b0, 1'b1, 9, rnd256());
    clr = 1'b0;
    chk_status();

    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2: av_cmd(1'b0, 1'b1, int'($urandom_range(0, DEPTH + 1)), rnd256());
        3, 4, 5: av_cmd(1'b1, 1'b0, int'($urandom_range(0, DEPTH + 1)), '0);
        6, 7:    host_wr(int'($urandom_range(0, 47)), int'($urandom_range(0, 7)), $urandom);
        8:       host_rd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)));
        default: begin
          if ($urandom_range(0, 3) == 0) clr_pulse();
          else av_cmd(1'b1, 1'b1, int'($urandom_range(0, DEPTH + 1)), rnd256());
        end
      endcase
      chk_status();
    end

    // Saturation of res_count at 255.
    clr_pulse();
    for (int i = 0; i < 260; i++) begin
      av_cmd(1'b0, 1'b1, 2 + int'($urandom_range(0, DEPTH - 3)), rnd256());
      if (i == 254 || i == 259) chk_status();
    end

    // Reset in the second cycle of a read: everything returns to zero.
    avs_address = {27'd5, 5'd0};
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    avs_read = 1'b0;
    #1;
    rd_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    expect_st(cyc, K_VALID, '0);
    expect_st(cyc, K_RDATA, '0);
    expect_st(cyc, K_HRD, '0);
    expect_st(cyc, K_WREQ, '0);
    chk_status();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    av_cmd(1'b1, 1'b0, 5, '0);
    host_rd(5, 3);
    chk_status();

    idle(5);
    expect_st(cyc, K_PEND, '0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
